// File: rtl/send_pkt_demux_pkg.sv
// Local constants and sizing helpers for the send packet demultiplexer.
package send_pkt_demux_pkg;

    localparam int unsigned NUM_DST = 2;

    function automatic int unsigned buf_ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned buf_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tcp_pkg.sv
// Shared TCP packet definitions used by the send-path blocks.
package tcp_pkg;

    typedef struct packed {
        logic [15:0] pkt_len;
        logic [31:0] seq_num;
        logic [7:0]  flags;
    } send_pkt_struct;

    localparam int SEND_PKT_STRUCT_W = $bits(send_pkt_struct);

endpackage

// File: rtl/send_pkt_demux_buf.sv
// Single-read/single-write circular FIFO with registered full/empty flags.
module send_pkt_demux_buf
    import tcp_pkg::*;
    import send_pkt_demux_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           push_val_i,
    input  send_pkt_struct push_data_i,
    output logic           push_rdy_o,
    output logic           pop_val_o,
    output send_pkt_struct pop_data_o,
    input  logic           pop_rdy_i
);

    localparam int unsigned PtrW = buf_ptr_w(BUF_DEPTH);
    localparam int unsigned CntW = buf_cnt_w(BUF_DEPTH);

    send_pkt_struct mem_q [BUF_DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            push;
    logic            pop;

    // Flags are gated by reset so the block presents idle handshakes while held.
    assign push_rdy_o = rst_ni & ~full_q;
    assign pop_val_o  = rst_ni & ~empty_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign push = push_val_i & push_rdy_o;
    assign pop  = pop_val_o & pop_rdy_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == CntW'(BUF_DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is not reset; only the pointers decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/send_pkt_demux.sv
// Steers send packets into one of two output FIFOs and muxes back the input ready.
module send_pkt_demux
    import tcp_pkg::*;
    import send_pkt_demux_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           src_demux_val,
    input  send_pkt_struct src_demux_data,
    input  logic           src_demux_sel,
    output logic           demux_src_rdy,
    output logic           demux_dst0_val,
    output send_pkt_struct demux_dst0_data,
    input  logic           dst0_demux_rdy,
    output logic           demux_dst1_val,
    output send_pkt_struct demux_dst1_data,
    input  logic           dst1_demux_rdy
);

    logic [NUM_DST-1:0] push_val;
    logic [NUM_DST-1:0] push_rdy;

    assign push_val[0]   = src_demux_val & ~src_demux_sel;
    assign push_val[1]   = src_demux_val & src_demux_sel;
    // Ready comes only from the registered full flag of the selected buffer.
    assign demux_src_rdy = src_demux_sel ? push_rdy[1] : push_rdy[0];

    send_pkt_demux_buf #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf0 (
        .clk_i       (clk),
        .rst_ni      (rst),
        .push_val_i  (push_val[0]),
        .push_data_i (src_demux_data),
        .push_rdy_o  (push_rdy[0]),
        .pop_val_o   (demux_dst0_val),
        .pop_data_o  (demux_dst0_data),
        .pop_rdy_i   (dst0_demux_rdy)
    );

    send_pkt_demux_buf #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf1 (
        .clk_i       (clk),
        .rst_ni      (rst),
        .push_val_i  (push_val[1]),
        .push_data_i (src_demux_data),
        .push_rdy_o  (push_rdy[1]),
        .pop_val_o   (demux_dst1_val),
        .pop_data_o  (demux_dst1_data),
        .pop_rdy_i   (dst1_demux_rdy)
    );

endmodule
